// File: rtl/tp_sequencer_if.sv
// -----------------------------------------------------------------------------
// tp_sequencer_if
// Request/acknowledge bus between the config/OSD CPU and the test-pattern
// sequencer.
//   req      level request, held by the CPU until ack
//   req_en   requested pattern enable
//   req_sel  requested pattern select
//   ack      one-VCLK pulse when the request has been committed
//   busy     a request is latched and waiting for vertical sync
// Modports: master = CPU side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface tp_sequencer_if;
    logic       req;
    logic       req_en;
    logic [1:0] req_sel;
    logic       ack;
    logic       busy;

    modport master (output req, req_en, req_sel, input ack, busy);
    modport slave  (input req, req_en, req_sel, output ack, busy);
endinterface

// File: rtl/tp_sequencer.sv
// -----------------------------------------------------------------------------
// tp_sequencer
// Frame-synchronous controller for the test-pattern datapath. Pattern
// enable/select requests from the CPU are latched and only committed on a
// falling edge of nVSYNC, so a pattern change never tears mid-frame. A
// palmode flip while a pattern is shown blanks the colour outputs for one
// frame.
//
// Build option: define TP_AUTOCYCLE_EN to auto-advance pattern_sel every
// CYCLE_FRAMES_NTSC / CYCLE_FRAMES_PAL frames while a pattern is active.
//
// Ports
//   VCLK         video clock
//   nRST         asynchronous active-low reset
//   nVDSYNC      data-phase strobe, low = sample cycle; all state updates
//                are gated on it
//   Sync_in      {nVSYNC,nCLAMP,nHSYNC,nCSYNC}; only nVSYNC is used here
//   palmode      0 NTSC, 1 PAL
//   bus          request bus (slave side): req/req_en/req_sel in, ack/busy out
//   pattern_en   1 = mux selects the pattern generator, 0 = live video
//   pattern_sel  active pattern index
//   blank        1 = force colour outputs to 0 (sync passes through)
// -----------------------------------------------------------------------------
module tp_sequencer #(
    parameter int unsigned CYCLE_FRAMES_NTSC = 120,
    parameter int unsigned CYCLE_FRAMES_PAL  = 100
) (
    input  logic                 VCLK,
    input  logic                 nRST,
    input  logic                 nVDSYNC,
    input  logic [3:0]           Sync_in,
    input  logic                 palmode,
    tp_sequencer_if.slave        bus,
    output logic                 pattern_en,
    output logic [1:0]           pattern_sel,
    output logic                 blank
);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t     state;
    logic       vsync_q;
    logic       pal_q;
    logic       from_active;   // state to return to if req is withdrawn
    logic       pal_pend;      // palmode flipped while armed, not yet acted on
    logic       lat_en;
    logic [1:0] lat_sel;

    logic       strobe;
    logic       vsync_fall;
    logic       pal_edge;

    // Only nVSYNC matters to this block; the other sync lines pass elsewhere.
    logic       unused_sync;
    assign unused_sync = ^Sync_in[2:0];

    assign strobe     = ~nVDSYNC;
    assign vsync_fall = vsync_q & ~Sync_in[3];
    assign pal_edge   = palmode ^ pal_q;

`ifdef TP_AUTOCYCLE_EN
    logic [7:0] frame_cnt;
    logic [7:0] cycle_last;

    // Limit follows the palmode currently in force.
    assign cycle_last = palmode ? 8'(CYCLE_FRAMES_PAL - 1)
                                : 8'(CYCLE_FRAMES_NTSC - 1);

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction
`else
    logic [15:0] unused_cfg;
    assign unused_cfg = {8'(CYCLE_FRAMES_NTSC), 8'(CYCLE_FRAMES_PAL)};
`endif

    // ---- request capture: latest en/sel wins while the request is open ----
    always_ff @(posedge VCLK) begin
        if (strobe && bus.req && (state != RESYNC)) begin
            lat_en  <= bus.req_en;
            lat_sel <= bus.req_sel;
        end
    end

    // ---- control FSM with registered outputs ----
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state       <= LIVE;
            vsync_q     <= 1'b1;
            pal_q       <= 1'b0;
            from_active <= 1'b0;
            pal_pend    <= 1'b0;
            pattern_en  <= 1'b0;
            pattern_sel <= 2'd0;
            blank       <= 1'b0;
            bus.ack     <= 1'b0;
            bus.busy    <= 1'b0;
`ifdef TP_AUTOCYCLE_EN
            frame_cnt   <= 8'd0;
`endif
        end else begin
            // ack is a single VCLK pulse regardless of strobe spacing.
            bus.ack <= 1'b0;

            if (strobe) begin
                vsync_q <= Sync_in[3];
                pal_q   <= palmode;

                case (state)
                    LIVE: begin
                        // palmode changes do not matter while showing live video.
                        if (bus.req) begin
                            state       <= ARMED;
                            bus.busy    <= 1'b1;
                            from_active <= 1'b0;
                            pal_pend    <= 1'b0;
                        end
                    end

                    ACTIVE: begin
                        if (pal_edge) begin
                            blank <= 1'b1;
                            state <= RESYNC;
                        end else begin
`ifdef TP_AUTOCYCLE_EN
                            if (vsync_fall) begin
                                if (frame_cnt == cycle_last) begin
                                    pattern_sel <= next_sel(pattern_sel);
                                    frame_cnt   <= 8'd0;
                                end else begin
                                    frame_cnt <= frame_cnt + 8'd1;
                                end
                            end
`endif
                            if (bus.req) begin
                                state       <= ARMED;
                                bus.busy    <= 1'b1;
                                from_active <= 1'b1;
                                pal_pend    <= 1'b0;
                            end
                        end
                    end

                    ARMED: begin
                        if (!bus.req) begin
                            // Withdrawn request: outputs untouched, no ack. A
                            // palmode flip seen meanwhile still forces a resync
                            // if a pattern is on screen.
                            bus.busy <= 1'b0;
                            pal_pend <= 1'b0;
                            if (from_active && (pal_edge || pal_pend)) begin
                                blank <= 1'b1;
                                state <= RESYNC;
                            end else begin
                                state <= from_active ? ACTIVE : LIVE;
                            end
                        end else if (vsync_fall && pal_edge) begin
                            // Coincident palmode flip wins: this frame is
                            // blanked and the commit waits one more frame.
                            blank    <= 1'b1;
                            pal_pend <= 1'b0;
                        end else if (vsync_fall) begin
                            pattern_en  <= lat_en;
                            pattern_sel <= lat_sel;
                            bus.ack     <= 1'b1;
                            bus.busy    <= 1'b0;
                            pal_pend    <= 1'b0;
`ifdef TP_AUTOCYCLE_EN
                            frame_cnt   <= 8'd0;
`endif
                            if (lat_en && pal_pend) begin
                                blank <= 1'b1;
                                state <= RESYNC;
                            end else begin
                                blank <= 1'b0;
                                state <= lat_en ? ACTIVE : LIVE;
                            end
                        end else if (pal_edge) begin
                            pal_pend <= 1'b1;
                        end
                    end

                    RESYNC: begin
                        // Requests are held off until the blanked frame ends.
                        if (vsync_fall) begin
                            blank <= 1'b0;
                            state <= ACTIVE;
`ifdef TP_AUTOCYCLE_EN
                            frame_cnt <= 8'd0;
`endif
                        end
                    end

                    default: state <= LIVE;
                endcase
            end
        end
    end

endmodule
